// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch constants and state encodings
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_TRAP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch unit bus to imem and decode; MISALIGN_TRAP_EN adds misalign_trap
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall_in;
  logic              redirect_valid;
  logic [31:0]       redirect_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic [31:0]       if_pc_plus4;
  logic              if_valid;
`ifdef MISALIGN_TRAP_EN
  logic              misalign_trap;
`endif

  modport master (
    input  stall_in, redirect_valid, redirect_target, imem_rdata,
`ifdef MISALIGN_TRAP_EN
    output misalign_trap,
`endif
    output imem_addr, if_instr, if_pc, if_pc_plus4, if_valid
  );

  modport slave (
    output stall_in, redirect_valid, redirect_target, imem_rdata,
`ifdef MISALIGN_TRAP_EN
    input  misalign_trap,
`endif
    input  imem_addr, if_instr, if_pc, if_pc_plus4, if_valid
  );

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 32-bit program counter with sync reset, load and hold
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        hold,
  output logic [31:0] pc_q
);

  logic [31:0] pc_d;

  // Load wins over hold; otherwise advance one word, wrapping at 2^32.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (load) begin
      pc_d = load_value;
    end else if (hold) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch front end; MISALIGN_TRAP_EN enables the misaligned-redirect trap
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input logic              clk,
  input logic              reset,
  pc_fetch_unit_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  pc_q;
  logic [31:0]  target;
  logic [31:0]  addr_pc;
  logic         pc_load;
  logic         pc_hold;

`ifdef MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign target = bus.redirect_target;
`else
  assign target = bus.redirect_target & ~32'h3;
`endif

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (pc_load),
    .load_value (target),
    .hold       (pc_hold),
    .pc_q       (pc_q)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if_valid_d = if_valid_q;
    pc_load    = 1'b0;
    pc_hold    = 1'b1;
`ifdef MISALIGN_TRAP_EN
    trap_d     = trap_q;
`endif
    if (state_q == S_TRAP) begin
      if_valid_d = 1'b0;
    end else if (bus.redirect_valid) begin
      // The word arriving next cycle is from the killed path, so drop valid.
      if_valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (target[1:0] != 2'b00) begin
        trap_d  = 1'b1;
        state_d = S_TRAP;
      end else
`endif
      begin
        pc_load = 1'b1;
        state_d = S_FLUSH;
      end
    end else if (!bus.stall_in) begin
      fetch_pc_d = pc_q;
      pc_hold    = 1'b0;
      if_valid_d = 1'b1;
      state_d    = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= 32'h0000_0000;
      if_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_valid_q <= if_valid_d;
`ifdef MISALIGN_TRAP_EN
      trap_q     <= trap_d;
`endif
    end
  end

  // While stalled, re-read the word already on if_instr so it stays stable.
  assign addr_pc         = (bus.stall_in && !bus.redirect_valid) ? fetch_pc_q : pc_q;
  assign bus.imem_addr   = ADDR_W'(addr_pc >> 2);
  assign bus.if_instr    = if_valid_q ? bus.imem_rdata : NOP_INSTR;
  assign bus.if_pc       = fetch_pc_q;
  assign bus.if_pc_plus4 = fetch_pc_q + 32'd4;
  assign bus.if_valid    = if_valid_q;
`ifdef MISALIGN_TRAP_EN
  assign bus.misalign_trap = trap_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed testbench for pc_fetch_unit
module tb_pc_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(32)) bus0 ();
  pc_fetch_unit_if #(.ADDR_W(32)) bus1 ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .ADDR_W(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always @(posedge clk) begin
    bus0.imem_rdata <= mem[bus0.imem_addr[5:0]];
    bus1.imem_rdata <= mem[bus1.imem_addr[5:0]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus0.stall_in = 1'b0;
    bus0.redirect_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus0.stall_in = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_target = 32'h0;
    bus1.stall_in = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_target = 32'h0;
    tick();
    tick();
    checks++;
    if (bus0.if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus0.if_valid); end
    checks++;
    if (bus0.if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h want 00000000", bus0.if_pc); end
    checks++;
    if (bus0.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got %h want 00000000", bus0.imem_addr); end
    checks++;
    if (bus0.if_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_nop got %h want 00000013", bus0.if_instr); end
    checks++;
    if (bus1.imem_addr !== 32'h3FFF_FFFE) begin failures++; $display("FAIL reset_addr_hi got %h want 3ffffffe", bus1.imem_addr); end
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (bus0.misalign_trap !== 1'b0) begin failures++; $display("FAIL reset_trap got %b want 0", bus0.misalign_trap); end
`endif
    reset = 1'b0;
    checks++;
    if (bus0.if_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got %b want 0", bus0.if_valid); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_pc [0:2];
    logic [31:0] exp_instr [0:2];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    exp_instr = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus0.if_valid !== 1'b1 || bus0.if_pc !== exp_pc[i] || bus0.if_instr !== exp_instr[i])
        begin failures++; $display("FAIL seq%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, bus0.if_valid, bus0.if_pc, bus0.if_instr, exp_pc[i], exp_instr[i]); end
      checks++;
      if (bus0.if_pc_plus4 !== exp_pc[i] + 32'd4) begin failures++; $display("FAIL seq_plus4_%0d got %h want %h", i, bus0.if_pc_plus4, exp_pc[i] + 32'd4); end
    end
  endtask

  task automatic test_stall;
    bus0.stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus0.if_valid !== 1'b1 || bus0.if_pc !== 32'h8 || bus0.if_instr !== 32'hA000_0002)
        begin failures++; $display("FAIL stall%0d got v=%b pc=%h instr=%h want v=1 pc=00000008 instr=a0000002", k, bus0.if_valid, bus0.if_pc, bus0.if_instr); end
      if (k == 2) bus0.stall_in = 1'b0;
      tick();
    end
    checks++;
    if (bus0.if_valid !== 1'b1 || bus0.if_pc !== 32'hC || bus0.if_instr !== 32'hA000_0003)
      begin failures++; $display("FAIL stall_release got v=%b pc=%h instr=%h want v=1 pc=0000000c instr=a0000003", bus0.if_valid, bus0.if_pc, bus0.if_instr); end
  endtask

  task automatic test_reset_mid_stall;
    bus0.stall_in = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus0.if_valid !== 1'b0 || bus0.if_pc !== 32'h0 || bus0.imem_addr !== 32'h0)
      begin failures++; $display("FAIL reset_mid_stall got v=%b pc=%h addr=%h want v=0 pc=0 addr=0", bus0.if_valid, bus0.if_pc, bus0.imem_addr); end
    reset = 1'b0;
    bus0.stall_in = 1'b0;
  endtask

  task automatic test_redirect;
    tick();
    tick();
    checks++;
    if (bus0.if_pc !== 32'h4) begin failures++; $display("FAIL redir_pre_pc got %h want 00000004", bus0.if_pc); end
    bus0.redirect_valid = 1'b1;
    bus0.redirect_target = 32'h40;
    tick();
    bus0.redirect_valid = 1'b0;
    checks++;
    if (bus0.if_valid !== 1'b0 || bus0.if_instr !== 32'h0000_0013 || bus0.imem_addr !== 32'h10)
      begin failures++; $display("FAIL redir_flush got v=%b instr=%h addr=%h want v=0 instr=00000013 addr=00000010", bus0.if_valid, bus0.if_instr, bus0.imem_addr); end
    tick();
    checks++;
    if (bus0.if_valid !== 1'b1 || bus0.if_pc !== 32'h40 || bus0.if_instr !== 32'hA000_0010 || bus0.if_pc_plus4 !== 32'h44)
      begin failures++; $display("FAIL redir_target got v=%b pc=%h instr=%h p4=%h want v=1 pc=00000040 instr=a0000010 p4=00000044", bus0.if_valid, bus0.if_pc, bus0.if_instr, bus0.if_pc_plus4); end
    tick();
    checks++;
    if (bus0.if_pc !== 32'h44 || bus0.if_instr !== 32'hA000_0011)
      begin failures++; $display("FAIL redir_next got pc=%h instr=%h want pc=00000044 instr=a0000011", bus0.if_pc, bus0.if_instr); end
  endtask

  task automatic test_redirect_stall;
    bus0.redirect_valid = 1'b1;
    bus0.stall_in = 1'b1;
    bus0.redirect_target = 32'h20;
    checks++;
    if (bus0.imem_addr !== 32'h12) begin failures++; $display("FAIL rs_addr got %h want 00000012", bus0.imem_addr); end
    tick();
    bus0.redirect_valid = 1'b0;
    bus0.stall_in = 1'b0;
    checks++;
    if (bus0.if_valid !== 1'b0) begin failures++; $display("FAIL rs_flush got v=%b want 0", bus0.if_valid); end
    tick();
    checks++;
    if (bus0.if_valid !== 1'b1 || bus0.if_pc !== 32'h20 || bus0.if_instr !== 32'hA000_0008)
      begin failures++; $display("FAIL rs_target got v=%b pc=%h instr=%h want v=1 pc=00000020 instr=a0000008", bus0.if_valid, bus0.if_pc, bus0.if_instr); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_pc [0:2];
    logic [31:0] exp_p4 [0:2];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_p4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    checks++;
    if (bus1.if_valid !== 1'b0) begin failures++; $display("FAIL wrap_boot got v=%b want 0", bus1.if_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus1.if_valid !== 1'b1 || bus1.if_pc !== exp_pc[i] || bus1.if_pc_plus4 !== exp_p4[i])
        begin failures++; $display("FAIL wrap%0d got v=%b pc=%h p4=%h want v=1 pc=%h p4=%h", i, bus1.if_valid, bus1.if_pc, bus1.if_pc_plus4, exp_pc[i], exp_p4[i]); end
    end
  endtask

  task automatic test_misalign;
    do_reset();
    tick();
    tick();
    bus0.redirect_valid = 1'b1;
    bus0.redirect_target = 32'h42;
    tick();
    bus0.redirect_valid = 1'b0;
    checks++;
    if (bus0.if_valid !== 1'b0) begin failures++; $display("FAIL mis_flush got v=%b want 0", bus0.if_valid); end
`ifdef MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus0.misalign_trap !== 1'b1 || bus0.if_valid !== 1'b0 || bus0.if_instr !== 32'h0000_0013)
        begin failures++; $display("FAIL mis_trap%0d got trap=%b v=%b instr=%h want trap=1 v=0 instr=00000013", k, bus0.misalign_trap, bus0.if_valid, bus0.if_instr); end
      tick();
    end
    do_reset();
    checks++;
    if (bus0.misalign_trap !== 1'b0) begin failures++; $display("FAIL mis_clear got %b want 0", bus0.misalign_trap); end
`else
    tick();
    checks++;
    if (bus0.if_valid !== 1'b1 || bus0.if_pc !== 32'h40 || bus0.if_instr !== 32'hA000_0010)
      begin failures++; $display("FAIL mis_align got v=%b pc=%h instr=%h want v=1 pc=00000040 instr=a0000010", bus0.if_valid, bus0.if_pc, bus0.if_instr); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    test_reset();
    test_sequential();
    test_stall();
    test_reset_mid_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
